// File: rtl/labk_pkg.sv
// Shared definitions for the gate-level mux sign-off checker.
// Holds FSM state encoding, run limits and the saturating error increment.
// Purely declarative; no timing or flow-control behaviour of its own.
package labk_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [2:0] VEC_LAST = 3'd7;
    localparam logic [3:0] ERR_MAX  = 4'd15;

    // Error counter increments but sticks at ERR_MAX instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == ERR_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/labk_mux_ref.sv
// Golden 2:1 mux: z = c ? b : a.
// Latency: purely combinational.
// Backpressure: none; output follows inputs continuously.
module labk_mux_ref (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_z
);

    assign o_z = i_c ? i_b : i_a;

endmodule

// File: rtl/labk_mux_checker.sv
// Exhaustive checker: walks {a,b,c} through 0..7, samples the mux under test, counts mismatches.
// Latency: done pulses 1+8*(SETTLE_CYCLES+2) cycles after the start-accepting edge.
// Backpressure: start is honoured in IDLE only; requests while busy or in DONE are dropped.
module labk_mux_checker
    import labk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_a_out,
    output logic       o_b_out,
    output logic       o_c_out,
    input  logic       i_z_in,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic       o_first_fail_valid,
    output logic [2:0] o_first_fail_vec
);

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES);

    logic [1:0] r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_count;
    logic       r_ff_valid;
    logic [2:0] r_ff_vec;

    logic w_expected;
    logic w_start_acc;
    logic w_sample;
    logic w_mismatch;
    logic w_last_sample;

    // The vector register drives the mux pins directly, so the golden value
    // is computed from exactly what the mux under test is seeing.
    labk_mux_ref u_ref (
        .i_a (r_vec[2]),
        .i_b (r_vec[1]),
        .i_c (r_vec[0]),
        .o_z (w_expected)
    );

    assign w_start_acc   = (r_state == ST_IDLE) && i_start;
    assign w_sample      = (r_state == ST_SAMPLE);
    assign w_mismatch    = w_sample && (i_z_in != w_expected);
    assign w_last_sample = w_sample && (r_vec == VEC_LAST);

    // Sequencer: settle each vector for SETTLE_CYCLES+1 cycles, sample once, advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_SETTLE;
                        r_vec   <= 3'd0;
                        r_cnt   <= CNT_RELOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_vec == VEC_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_cnt   <= CNT_RELOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Run status: busy spans SETTLE/SAMPLE; done is high for exactly the DONE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_sample;
            if (w_start_acc) begin
                r_busy <= 1'b1;
            end else if (w_last_sample) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Result capture: the final sample's own mismatch must feed the pass verdict,
    // so pass looks at the current count and the same-cycle compare together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass      <= 1'b0;
            r_err_count <= 4'd0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= 3'd0;
        end else if (w_start_acc) begin
            r_pass      <= 1'b0;
            r_err_count <= 4'd0;
            r_ff_valid  <= 1'b0;
            r_ff_vec    <= 3'd0;
        end else begin
            if (w_mismatch) begin
                r_err_count <= sat_inc(r_err_count);
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_vec   <= r_vec;
                end
            end
            if (w_last_sample) begin
                r_pass <= (r_err_count == 4'd0) && !w_mismatch;
            end
        end
    end

    assign o_a_out            = r_vec[2];
    assign o_b_out            = r_vec[1];
    assign o_c_out            = r_vec[0];
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_pass             = r_pass;
    assign o_err_count        = r_err_count;
    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_labk_mux_checker.sv
// Bench for labk_mux_checker: two instances (settle 1 and settle 0) driving a modelled mux.
// Mux model can be golden, z=a, stuck-at-1, or golden with a random per-vector flip mask.
// Expected results come from counting/locating faulty vectors directly.
module tb_labk_mux_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, start0;

    logic a1, b1, c1, z1, busy1, done1, pass1, ffv1;
    logic [3:0] err1;
    logic [2:0] ffvec1;

    logic a0, b0, c0, z0, busy0, done0, pass0, ffv0;
    logic [3:0] err0;
    logic [2:0] ffvec0;

    int         mode;
    logic [7:0] fmask;
    logic [2:0] vec1;

    int vectors;
    int miscompares;

    int   vcount1 [8];
    int   vcount0 [8];
    logic snap_busy, snap_pass, snap_ffv;
    logic [3:0] snap_err;
    logic [2:0] snap_ffvec;

    labk_mux_checker #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
        .o_a_out(a1), .o_b_out(b1), .o_c_out(c1), .i_z_in(z1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_first_fail_valid(ffv1), .o_first_fail_vec(ffvec1)
    );

    labk_mux_checker #(.SETTLE_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0),
        .o_a_out(a0), .o_b_out(b0), .o_c_out(c0), .i_z_in(z0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0),
        .o_first_fail_valid(ffv0), .o_first_fail_vec(ffvec0)
    );

    assign vec1 = {a1, b1, c1};

    // Mux under test for instance 1
    always_comb begin
        case (mode)
            1:       z1 = a1;
            2:       z1 = 1'b1;
            default: z1 = (c1 ? b1 : a1) ^ fmask[vec1];
        endcase
    end

    assign z0 = c0 ? b0 : a0;

    // Start a run on dut1 and wait for done; lat is the 1-based cycle of done, -1 on timeout.
    task automatic run1(input int pulse_vec, output int lat);
        bit pulsed = 0;
        lat = -1;
        for (int i = 0; i < 8; i++) vcount1[i] = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        snap_busy = busy1; snap_pass = pass1; snap_ffv = ffv1;
        snap_err = err1; snap_ffvec = ffvec1;
        for (int n = 0; n < 400; n++) begin
            if (done1) begin
                lat = n + 1;
                break;
            end
            if (busy1) vcount1[vec1]++;
            start1 = 1'b0;
            if (!pulsed && pulse_vec >= 0 && busy1 && int'(vec1) == pulse_vec) begin
                start1 = 1'b1;
                pulsed = 1;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; mode = 0; fmask = 8'h00;
        #1;
        vectors++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, ffv1, ffvec1} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {a1, b1, c1, busy1, done1, pass1, err1, ffv1, ffvec1});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_mux();
        int lat;
        mode = 0; fmask = 8'h00;
        run1(-1, lat);
        vectors++;
        if (lat !== 25) begin miscompares++; $display("FAIL good_latency: got %0d expected 25", lat); end
        vectors++;
        if ({pass1, err1, ffv1, busy1} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL good_result: pass/err/ffv/busy got %b/%0d/%b/%b expected 1/0/0/0", pass1, err1, ffv1, busy1);
        end
        for (int v = 0; v < 8; v++) begin
            vectors++;
            if (vcount1[v] !== 3) begin
                miscompares++;
                $display("FAIL good_vec_hold[%0d]: got %0d cycles expected 3", v, vcount1[v]);
            end
        end
        @(negedge clk);
        vectors++;
        if ({done1, pass1, vec1} !== {1'b0, 1'b1, 3'b111}) begin
            miscompares++;
            $display("FAIL good_after_done: done/pass/vec got %b/%b/%b expected 0/1/111", done1, pass1, vec1);
        end
    endtask

    task automatic test_fault_z_eq_a();
        int lat;
        mode = 1;
        run1(-1, lat);
        vectors++;
        if ({lat, err1, ffv1, ffvec1, pass1} !== {32'd25, 4'd2, 1'b1, 3'b011, 1'b0}) begin
            miscompares++;
            $display("FAIL z_eq_a: lat/err/ffv/ffvec/pass got %0d/%0d/%b/%b/%b expected 25/2/1/011/0",
                     lat, err1, ffv1, ffvec1, pass1);
        end
    endtask

    task automatic test_stuck1();
        int lat;
        mode = 2;
        run1(-1, lat);
        vectors++;
        if ({lat, err1, ffv1, ffvec1, pass1} !== {32'd25, 4'd4, 1'b1, 3'b000, 1'b0}) begin
            miscompares++;
            $display("FAIL stuck1: lat/err/ffv/ffvec/pass got %0d/%0d/%b/%b/%b expected 25/4/1/000/0",
                     lat, err1, ffv1, ffvec1, pass1);
        end
    endtask

    task automatic test_random_faults();
        int lat, exp_err, exp_first;
        for (int it = 0; it < 8; it++) begin
            mode = 0;
            fmask = (it == 0) ? 8'h80 : 8'($urandom);
            exp_err = 0; exp_first = -1;
            for (int v = 0; v < 8; v++) begin
                if (fmask[v]) begin
                    exp_err++;
                    if (exp_first < 0) exp_first = v;
                end
            end
            run1(-1, lat);
            vectors++;
            if (lat !== 25 || int'(err1) !== exp_err || pass1 !== (exp_err == 0) ||
                ffv1 !== (exp_err != 0) || int'(ffvec1) !== ((exp_first < 0) ? 0 : exp_first)) begin
                miscompares++;
                $display("FAIL random_mask %b: lat/err/pass/ffv/ffvec got %0d/%0d/%b/%b/%0d expected 25/%0d/%0d/%0d/%0d",
                         fmask, lat, err1, pass1, ffv1, ffvec1, exp_err, exp_err == 0, exp_err != 0,
                         (exp_first < 0) ? 0 : exp_first);
            end
        end
        fmask = 8'h00;
    endtask

    task automatic test_start_ignored();
        int lat;
        mode = 2;
        run1(3, lat);
        vectors++;
        if ({lat, err1} !== {32'd25, 4'd4}) begin
            miscompares++;
            $display("FAIL start_while_busy: lat/err got %0d/%0d expected 25/4", lat, err1);
        end
        mode = 0;
        run1(-1, lat);
        vectors++;
        if ({snap_busy, snap_err, snap_ffv, snap_ffvec, snap_pass} !== {1'b1, 4'd0, 1'b0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL restart_clear: busy/err/ffv/ffvec/pass got %b/%0d/%b/%b/%b expected 1/0/0/000/0",
                     snap_busy, snap_err, snap_ffv, snap_ffvec, snap_pass);
        end
        vectors++;
        if ({lat, pass1, err1} !== {32'd25, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL restart_run: lat/pass/err got %0d/%b/%0d expected 25/1/0", lat, pass1, err1);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        mode = 0;
        @(negedge clk); start1 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done1) begin lat = n; break; end
        end
        @(negedge clk);
        vectors++;
        if ({lat >= 0, busy1} !== 2'b10) begin
            miscompares++;
            $display("FAIL held_start_idle: done_seen/busy got %b/%b expected 1/0", lat >= 0, busy1);
        end
        @(negedge clk);
        vectors++;
        if ({busy1, vec1} !== {1'b1, 3'b000}) begin
            miscompares++;
            $display("FAIL held_start_retrigger: busy/vec got %b/%b expected 1/000", busy1, vec1);
        end
        start1 = 1'b0;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            if (done1) begin lat = n; break; end
            @(negedge clk);
        end
        vectors++;
        if (lat < 0 || pass1 !== 1'b1) begin
            miscompares++;
            $display("FAIL held_start_run: done_seen/pass got %b/%b expected 1/1", lat >= 0, pass1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int lat;
        int dones = 0;
        bit reached = 0;
        mode = 2;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (busy1 && vec1 == 3'd4) begin reached = 1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!reached || err1 !== 4'd3) begin
            miscompares++;
            $display("FAIL midrun_reach: reached/err got %b/%0d expected 1/3", reached, err1);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, ffv1, ffvec1} !== 13'd0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got %b expected all zero",
                     {a1, b1, c1, busy1, done1, pass1, err1, ffv1, ffvec1});
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            if (done1) dones++;
        end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("FAIL midrun_no_done: got %0d pulses expected 0", dones); end
        mode = 0;
        run1(-1, lat);
        vectors++;
        if ({lat, pass1, err1, ffv1} !== {32'd25, 1'b1, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset_run: lat/pass/err/ffv got %0d/%b/%0d/%b expected 25/1/0/0", lat, pass1, err1, ffv1);
        end
    endtask

    task automatic test_settle0();
        int lat = -1;
        for (int i = 0; i < 8; i++) vcount0[i] = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done0) begin lat = n + 1; break; end
            if (busy0) vcount0[{a0, b0, c0}]++;
            @(negedge clk);
        end
        vectors++;
        if ({lat, pass0, err0, ffv0} !== {32'd17, 1'b1, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL settle0_run: lat/pass/err/ffv got %0d/%b/%0d/%b expected 17/1/0/0", lat, pass0, err0, ffv0);
        end
        for (int v = 0; v < 8; v++) begin
            vectors++;
            if (vcount0[v] !== 2) begin
                miscompares++;
                $display("FAIL settle0_vec_hold[%0d]: got %0d cycles expected 2", v, vcount0[v]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_good_mux();
        test_fault_z_eq_a();
        test_stuck1();
        test_random_faults();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_settle0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
